// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master req/ack arbiter in front of a single-port memory.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed m0 priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  output logic              grant
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              grant_q, grant_d;
  logic              any_req;
  logic              win1;

  assign any_req = m0_req | m1_req;

`ifdef ARB_FIXED_PRIO_EN
  assign win1 = m1_req & ~m0_req;
`else
  logic last_q, last_d;
  // On contention the master that was not granted last wins.
  assign win1 = m1_req & (~m0_req | ~last_q);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    grant_d = grant_q;
`ifndef ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE, RESP: begin
        if (any_req) begin
          state_d = ACCESS;
          grant_d = win1;
          we_d    = win1 ? m1_we    : m0_we;
          addr_d  = win1 ? m1_addr  : m0_addr;
          wdata_d = win1 ? m1_wdata : m0_wdata;
`ifndef ARB_FIXED_PRIO_EN
          last_d  = win1;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      grant_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      grant_q <= grant_d;
`ifndef ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign mem_address  = addr_q;
  assign mem_data_out = wdata_q;
  assign mem_we       = we_q;
  assign m0_ack       = ack0_q;
  assign m1_ack       = ack1_q;
  assign grant        = grant_q;
  assign m0_rdata     = mem_data_in;
  assign m1_rdata     = mem_data_in;

endmodule
